hog_cell_feeder: RTL
====================

// Module: hog_cell_feeder
// PURPOSE
//   Producer end of the HOG cell-fetch interface. Accepts a bordered cell serially, one pixel per beat.
//   Packs each cell into one PIX_W*PIX_N word and buffers up to DEPTH cells in a FIFO.
//   Answers the fetch unit's request pulses with a one-cycle ready strobe and the oldest stored cell.
//   Sits between the frame/line buffer and hog_fetch in hog_svm.
// PARAMETERS
//   PIX_W   8   pixel width
//   CELL_S  10  bordered cell edge (8x8 cell + 1-pixel border)
//   DEPTH   4   cells buffered in the FIFO (power of 2, >=2)
//   PIX_N   localparam = CELL_S*CELL_S-4, pixels per cell (corners excluded), 96 by default
//   OUT_W   localparam = PIX_W*PIX_N
//   CNT_W   localparam = $clog2(DEPTH+1)
// PORTS
//   clk      in   1          clock; all logic on the rising edge
//   rst      in   1          synchronous reset, active-low
//   s_valid  in   1          upstream pixel valid
//   s_ready  out  1          upstream pixel ready; a beat transfers when s_valid & s_ready
//   s_data   in   PIX_W      pixel; row-major over the CELL_S x CELL_S window, 4 corners skipped
//   s_last   in   1          marks the last pixel of a cell
//   request  in   1          single-cycle pulse from fetch unit: deliver one cell
//   ready    out  1          one-cycle strobe; o_data is valid in this cycle
//   o_data   out  OUT_W      packed cell; pixel k at [k*PIX_W +: PIX_W], k=0 is the first received
//   count    out  CNT_W      cells currently stored in the FIFO
//   err      out  1          one-cycle pulse on a framing error
// BEHAVIOUR
//   Reset (rst=0 at a clock edge): ready=0, o_data=0, count=0, err=0, pixel index idx=0,
//     FIFO pointers=0, output FSM=IDLE. s_ready=1 in the cycle after reset.
//   Assembly
//     - Each accepted beat writes s_data to slot idx, then idx increments.
//     - At idx==PIX_N-1 with s_last=1: the cell {s_data, slots[PIX_N-2:0]} is pushed to the FIFO
//       in the same cycle and idx returns to 0.
//     - s_ready = !(idx==PIX_N-1 && count==DEPTH). Only the final beat stalls on a full FIFO.
//       A pop in the same cycle does not release the stall; s_ready rises the cycle after the pop.
//   Framing error: an accepted beat with s_last=1 at idx!=PIX_N-1, or with s_last=0 at
//     idx==PIX_N-1 -> err=1 next cycle, partial cell discarded, idx=0, nothing pushed.
//   FIFO: DEPTH x OUT_W registers with wrapping pointers.
//     - count updates on the cycle after a push/pop; push and pop in the same cycle leave count unchanged.
//     - empty = (count==0).
//   Output FSM (ready = state==SEND)
//     IDLE: request & !empty -> SEND (o_data<=head, pop); request & empty -> PEND
//     PEND: !empty -> SEND (load, pop); else stay. Further requests while pending are ignored (not queued).
//     SEND: request & !empty -> SEND (back-to-back delivery); request & empty -> PEND; else IDLE
//   Latency
//     - request at t with FIFO non-empty -> ready at t+1.
//     - Pending with last-beat push at t -> ready at t+2.
//   o_data holds the last delivered cell between strobes. Cells leave in push order.
//   Reset mid-operation discards the partial cell, all stored cells and any pending request.
// TESTING
//   1 Reset: hold rst=0 2 cycles -> ready=0, o_data=0, count=0, err=0, s_ready=1.
//   2 Single cell, pixel k = k, s_last on k=95. Then a request pulse at t
//       -> ready=1 only at t+1, o_data[k*8+:8]==k for all k, count returns 0.
//   3 Request pulse on empty FIFO; cell last beat at t -> ready at t+2 with that cell.
//       An extra request while in PEND produces no second strobe.
//   4 Push 4 cells, then 95 pixels of a 5th.
//       -> s_ready=0 at idx 95 and count=4.
//       -> A request returns cell 0; s_ready=1 the next cycle; the 5th cell is accepted.
//       -> Four more requests return cells 1..4 in order.
//   5 s_last at pixel 50 -> err pulse, count unchanged.
//       The following clean 96-pixel cell is delivered intact on request.
//   6 Mid-operation reset: 40 pixels assembled, 2 cells stored, request pending; rst=0 one cycle
//       -> count=0, no ready strobe, the next full cell is delivered as the only cell.

Source files
------------

// File: rtl/hog_cell_feeder.sv
// hog_cell_feeder: producer end of the HOG cell-fetch interface.
//   Gathers one bordered cell (corners skipped) pixel by pixel, packs it into a
//   single PIX_W*PIX_N word, buffers up to DEPTH cells and hands the oldest
//   one to the fetch unit on each request pulse with a one-cycle ready strobe.
// Ports:
//   clk      clock, rising edge
//   rst      synchronous reset, active-low
//   s_valid  upstream pixel valid
//   s_ready  upstream pixel ready (beat transfers on s_valid & s_ready)
//   s_data   pixel, row-major over the window with the 4 corners skipped
//   s_last   last pixel of a cell
//   request  single-cycle fetch request
//   ready    one-cycle strobe, o_data valid in that cycle
//   o_data   packed cell, pixel k at [k*PIX_W +: PIX_W]
//   count    cells stored in the FIFO
//   err      one-cycle framing-error pulse
module hog_cell_feeder #(
  parameter  int unsigned PIX_W  = 8,
  parameter  int unsigned CELL_S = 10,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned PIX_N  = CELL_S * CELL_S - 4,
  localparam int unsigned OUT_W  = PIX_W * PIX_N,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_last,
  input  logic             request,
  output logic             ready,
  output logic [OUT_W-1:0] o_data,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam int unsigned IDX_W = $clog2(PIX_N);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] o_data_q, o_data_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;

  // Slots for every pixel but the final one; the final pixel goes straight
  // into the pushed word so the cell is available the cycle it completes.
  logic [PIX_W-1:0] slot_q [PIX_N-1];
  logic [OUT_W-1:0] mem_q  [DEPTH];

  logic             at_last_c;
  logic             fire_c;
  logic             push_c;
  logic             frame_err_c;
  logic             slot_we_c;
  logic             pop_c;
  logic             empty_c;
  logic [OUT_W-1:0] cell_c;

  // Beat classification
  assign at_last_c   = (idx_q == IDX_W'(PIX_N - 1));
  // Only the closing beat needs FIFO space; earlier beats just fill slots.
  assign s_ready     = !(at_last_c && (count_q == CNT_W'(DEPTH)));
  assign fire_c      = s_valid & s_ready;
  assign push_c      = fire_c & at_last_c & s_last;
  assign frame_err_c = fire_c & (s_last != at_last_c);
  assign slot_we_c   = fire_c & !at_last_c & !s_last;
  assign empty_c     = (count_q == '0);

  // Packed cell: stored slots plus the beat currently on s_data
  always_comb begin
    cell_c = '0;
    for (int k = 0; k < int'(PIX_N) - 1; k++) begin
      cell_c[k*PIX_W +: PIX_W] = slot_q[k];
    end
    cell_c[OUT_W-1 -: PIX_W] = s_data;
  end

  // Pixel index and framing error
  always_comb begin
    idx_d = idx_q;
    err_d = frame_err_c;
    if (push_c || frame_err_c) begin
      idx_d = '0;
    end else if (fire_c) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Slot storage (data path only, no reset needed)
  always_ff @(posedge clk) begin
    if (slot_we_c) begin
      slot_q[idx_q] <= s_data;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= cell_c;
    end
  end

  // FIFO pointers and occupancy; pointers wrap since DEPTH is a power of 2
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Output FSM: next state, pop and output data
  always_comb begin
    state_d  = state_q;
    pop_c    = 1'b0;
    o_data_d = o_data_q;
    unique case (state_q)
      IDLE: begin
        if (request) begin
          if (!empty_c) begin
            state_d = SEND;
            pop_c   = 1'b1;
          end else begin
            state_d = PEND;
          end
        end
      end
      PEND: begin
        // Extra requests here are dropped, not queued.
        if (!empty_c) begin
          state_d = SEND;
          pop_c   = 1'b1;
        end
      end
      SEND: begin
        if (request && !empty_c) begin
          state_d = SEND;
          pop_c   = 1'b1;
        end else if (request) begin
          state_d = PEND;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (pop_c) begin
      o_data_d = mem_q[rd_ptr_q];
    end
    ready_d = (state_d == SEND);
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      o_data_q <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      o_data_q <= o_data_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign ready  = ready_q;
  assign o_data = o_data_q;
  assign count  = count_q;
  assign err    = err_q;

endmodule
